// File: rtl/sim_tohost_monitor.sv
// Simulation-side tohost/console responder: snoops the store port, reports end of test
// (pass/fail/timeout) after a drain window, and buffers console bytes in a small FIFO.
module sim_tohost_monitor #(
    parameter logic [31:0] TOHOST_ADDR    = 32'h0000_0100,
    parameter logic [31:0] CONSOLE_ADDR   = 32'h0000_0104,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned DRAIN_CYCLES   = 4,
    parameter int unsigned FIFO_DEPTH     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic [31:0] alu_result,
    input  logic [31:0] write_data,
    output logic        done,
    output logic        pass,
    output logic [30:0] fail_code,
    output logic        timeout,
    output logic [31:0] cycle_count,
    output logic        console_valid,
    output logic [7:0]  console_data,
    input  logic        console_ready,
    output logic        console_overflow
);

    localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t         state;
    logic [31:0]    latched;
    logic [DW-1:0]  drain_cnt;
    logic           end_store;

    assign end_store = mem_write && (alu_result == TOHOST_ADDR) && write_data[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_RUN;
            latched     <= '0;
            drain_cnt   <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_code   <= '0;
            timeout     <= 1'b0;
            cycle_count <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    cycle_count <= cycle_count + 32'd1;
                    // An end store on the limit edge takes priority over the timeout.
                    if (end_store) begin
                        latched   <= write_data;
                        drain_cnt <= DW'(DRAIN_CYCLES);
                        state     <= S_DRAIN;
                    end else if (cycle_count == 32'(TIMEOUT_CYCLES - 1)) begin
                        state   <= S_TIMEOUT;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    cycle_count <= cycle_count + 32'd1;
                    if (drain_cnt == DW'(1)) begin
                        state     <= S_DONE;
                        done      <= 1'b1;
                        pass      <= (latched == 32'h1);
                        fail_code <= (latched == 32'h1) ? '0 : latched[31:1];
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    logic          full;
    logic          push_ok;

    assign push          = mem_write && (alu_result == CONSOLE_ADDR);
    assign console_valid = (count != '0);
    assign pop           = console_valid && console_ready;
    assign full          = (count == (AW + 1)'(FIFO_DEPTH));
    assign push_ok       = push && (!full || pop);
    assign console_data  = fifo_mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            console_overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr] <= write_data[7:0];
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !push_ok) begin
                console_overflow <= 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sim_tohost_monitor.sv
// Bench for sim_tohost_monitor: table of end-of-test cases plus timeout, console FIFO and
// mid-drain reset sequences; console bytes are scoreboarded through a queue.
module tb_sim_tohost_monitor;

    localparam logic [31:0] TOHOST  = 32'h0000_0100;
    localparam logic [31:0] CONSOLE = 32'h0000_0104;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] alu_result = '0;
    logic [31:0] write_data = '0;
    logic        done;
    logic        pass;
    logic [30:0] fail_code;
    logic        timeout;
    logic [31:0] cycle_count;
    logic        console_valid;
    logic [7:0]  console_data;
    logic        console_ready = 1'b0;
    logic        console_overflow;

    sim_tohost_monitor #(
        .TOHOST_ADDR   (TOHOST),
        .CONSOLE_ADDR  (CONSOLE),
        .TIMEOUT_CYCLES(20),
        .DRAIN_CYCLES  (4),
        .FIFO_DEPTH    (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .mem_write       (mem_write),
        .alu_result      (alu_result),
        .write_data      (write_data),
        .done            (done),
        .pass            (pass),
        .fail_code       (fail_code),
        .timeout         (timeout),
        .cycle_count     (cycle_count),
        .console_valid   (console_valid),
        .console_data    (console_data),
        .console_ready   (console_ready),
        .console_overflow(console_overflow)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    logic [7:0] sb_q[$];
    logic       ovf_exp = 1'b0;

    typedef struct {
        logic [31:0] value;
        int          store_edge;
        logic        exp_pass;
        logic [30:0] exp_code;
        logic [31:0] exp_count;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    endtask

    // One clock: drive inputs, update the console model, advance to just after the edge.
    task automatic step(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic rdy);
        mem_write     = we;
        alu_result    = addr;
        write_data    = data;
        console_ready = rdy;
        if (console_valid && rdy) begin
            if (sb_q.size() == 0) begin
                check("console_unexpected_pop", 64'(console_data), 64'hx);
            end else begin
                check("console_head", 64'(console_data), 64'(sb_q[0]));
                void'(sb_q.pop_front());
            end
        end
        if (we && addr == CONSOLE) begin
            if (sb_q.size() < 8) sb_q.push_back(data[7:0]);
            else ovf_exp = 1'b1;
        end
        @(posedge clk);
        #1;
        mem_write     = 1'b0;
        console_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0);
    endtask

    // Reset asserted between edges; the next posedge after release is edge 1.
    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        sb_q.delete();
        ovf_exp = 1'b0;
    endtask

    task automatic drain_console(input string tag);
        for (int i = 0; i < 20 && console_valid; i++) step(1'b0, '0, '0, 1'b1);
        check({tag, "_empty_valid"}, 64'(console_valid), 64'd0);
        check({tag, "_empty_queue"}, 64'(sb_q.size()), 64'd0);
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{32'h0000_0001, 10, 1'b1, 31'h0,         32'd14};
        vecs[1] = '{32'h0000_0007, 3,  1'b0, 31'h3,         32'd7};
        vecs[2] = '{32'h8000_0001, 5,  1'b0, 31'h4000_0000, 32'd9};
        vecs[3] = '{32'hFFFF_FFFF, 1,  1'b0, 31'h7FFF_FFFF, 32'd5};

        reset = 1'b1;
        #12;
        reset = 1'b0;
        check("reset_done", 64'(done), 64'd0);
        check("reset_count", 64'(cycle_count), 64'd0);
        check("reset_valid", 64'(console_valid), 64'd0);
        check("reset_ovf", 64'(console_overflow), 64'd0);

        for (int v = 0; v < 4; v++) begin
            do_reset();
            idle(vecs[v].store_edge - 1);
            step(1'b1, TOHOST, vecs[v].value, 1'b0);
            idle(3);
            check("pre_done", 64'(done), 64'd0);
            idle(1);
            check("done", 64'(done), 64'd1);
            check("pass", 64'(pass), 64'(vecs[v].exp_pass));
            check("fail_code", 64'(fail_code), 64'(vecs[v].exp_code));
            check("timeout", 64'(timeout), 64'd0);
            check("cycle_count", 64'(cycle_count), 64'(vecs[v].exp_count));
            idle(3);
            check("count_frozen", 64'(cycle_count), 64'(vecs[v].exp_count));
        end

        // After a FAIL, a later store of 1 must not change the verdict.
        step(1'b1, TOHOST, 32'h1, 1'b0);
        idle(5);
        check("late_store_pass", 64'(pass), 64'd0);
        check("late_store_code", 64'(fail_code), 64'h7FFF_FFFF);

        // Timeout, with an ignored even-valued tohost store first.
        do_reset();
        step(1'b1, TOHOST, 32'h0, 1'b0);
        idle(4);
        check("even_store_ignored", 64'(done), 64'd0);
        begin
            int edges = 5;
            while (!done && edges < 60) begin
                idle(1);
                edges++;
            end
            check("timeout_edges", 64'(edges), 64'd20);
        end
        check("to_done", 64'(done), 64'd1);
        check("to_timeout", 64'(timeout), 64'd1);
        check("to_pass", 64'(pass), 64'd0);
        check("to_code", 64'(fail_code), 64'd0);
        check("to_count", 64'(cycle_count), 64'd20);

        // End store on the limit edge wins over timeout.
        do_reset();
        idle(19);
        step(1'b1, TOHOST, 32'h1, 1'b0);
        check("race_no_timeout", 64'(timeout), 64'd0);
        check("race_not_done", 64'(done), 64'd0);
        idle(4);
        check("race_done", 64'(done), 64'd1);
        check("race_pass", 64'(pass), 64'd1);
        check("race_count", 64'(cycle_count), 64'd24);

        // Overflow: 9 pushes into an 8-deep FIFO with no pops.
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, CONSOLE, 32'(8'h41 + i), 1'b0);
        check("ovf_set", 64'(console_overflow), 64'(ovf_exp));
        check("ovf_expected", 64'(ovf_exp), 64'd1);
        check("ovf_valid", 64'(console_valid), 64'd1);
        drain_console("ovf");
        check("ovf_sticky", 64'(console_overflow), 64'd1);

        // Full FIFO with simultaneous push and pop.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, CONSOLE, 32'(8'h41 + i), 1'b0);
        check("full_head", 64'(console_data), 64'h41);
        step(1'b1, CONSOLE, 32'h5A, 1'b1);
        check("pushpop_ovf", 64'(console_overflow), 64'd0);
        check("pushpop_model_size", 64'(sb_q.size()), 64'd8);
        drain_console("pushpop");
        check("pushpop_ovf_end", 64'(console_overflow), 64'd0);

        // Empty push becomes visible right after the edge.
        do_reset();
        step(1'b1, CONSOLE, 32'h31, 1'b0);
        check("empty_push_valid", 64'(console_valid), 64'd1);
        check("empty_push_data", 64'(console_data), 64'h31);

        // Reset mid-DRAIN, then a clean rerun.
        step(1'b1, TOHOST, 32'h1, 1'b0);
        idle(2);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_count", 64'(cycle_count), 64'd0);
        check("mid_rst_valid", 64'(console_valid), 64'd0);
        reset = 1'b0;
        sb_q.delete();
        ovf_exp = 1'b0;
        @(negedge clk);
        idle(1);
        check("after_rst_count", 64'(cycle_count), 64'd1);
        idle(8);
        step(1'b1, TOHOST, 32'h1, 1'b0);
        idle(3);
        check("rerun_pre_done", 64'(done), 64'd0);
        idle(1);
        check("rerun_done", 64'(done), 64'd1);
        check("rerun_pass", 64'(pass), 64'd1);
        check("rerun_count", 64'(cycle_count), 64'd14);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
